gray_capture: RTL and testbench
===============================

Name: gray_capture

Overview:
Sink-side counterpart of the gray test-pattern source. It consumes a hs/vs/de + 8-bit gray video stream, stores one ROW x COL frame into an internal frame buffer in raster order, and checks the frame geometry. A synchronous read port lets the bench or a downstream checker dump or compare the captured frame against the source hex image. It sits at the output of any processing stage under test in the video pipeline.

Parameters:
COL, `COL (50), active pixels per line
ROW, `ROW (50), active lines per frame
AW, $clog2(ROW*COL), frame buffer address width
CW, 12, width of the pixel-count and line-count statistics

Ports:
video_clk  in  1  pixel clock; all logic on its rising edge
rst  in  1  asynchronous reset, active-high
hs  in  1  horizontal sync; passed through to statistics only, not used for addressing
vs  in  1  frame valid; high for the whole frame, low in vertical blanking
de  in  1  pixel valid
iGray  in  8  pixel data; qualified by de
rd_addr  in  AW  frame buffer read address (raster index = (y-1)*COL + (x-1))
rd_data  out  8  frame buffer data; 1-cycle latency from rd_addr
frame_done  out  1  one-cycle pulse when a frame has been closed
frame_cnt  out  16  number of completed frames; wraps at 65535 -> 0
line_cnt  out  CW  de bursts counted in the last completed frame
err_len  out  1  last frame had a de burst length != COL
err_lines  out  1  last frame line_cnt != ROW
err_ovf  out  1  last frame delivered more than ROW*COL pixels; excess dropped

Behaviour:
- Reset state: FSM=IDLE; wr_ptr=0; frame_done=0; frame_cnt=0; line_cnt=0; all err_* =0; rd_data=0. Buffer contents are not cleared.
- Edge detect: vs_d, de_d registered copies. vs_rise = vs & ~vs_d; vs_fall = ~vs & vs_d; de_fall = ~de & de_d.
- FSM IDLE: de ignored, nothing written. On vs_rise -> CAPTURE and clear wr_ptr, run_len, line counter, and the working error flags. A frame already in progress when reset deasserts is never captured.
- FSM CAPTURE:
  - de=1 and wr_ptr < ROW*COL: write iGray to mem[wr_ptr] on the same edge, then wr_ptr+1.
  - de=1 and wr_ptr = ROW*COL: drop the pixel and set the working ovf flag.
  - run_len counts consecutive de cycles. On de_fall: line counter+1; run_len != COL sets the working len flag; run_len cleared.
  - On vs_fall -> DONE. If de is still high on that cycle, the open burst is counted and length-checked as if de_fall had occurred.
- FSM DONE, one cycle:
  - frame_done=1 for this cycle.
  - line_cnt, err_len, err_ovf latched from working state; err_lines = (line counter != ROW).
  - frame_cnt+1.
  - Next state is CAPTURE if vs_rise on this cycle, otherwise IDLE.
  - Status outputs hold until the next DONE.
- Latency: pixel written on the rising edge that samples de=1. frame_done is the cycle after vs is first sampled low.
- Simultaneous de_fall and vs_fall: both take effect, counted once.
- Reset asserted mid-frame: immediate IDLE. The partial frame is lost and the statistics are cleared.
- Read port: rd_data <= mem[rd_addr] every cycle, independent of capture. Read-during-write to the same address returns the old data. rd_addr >= ROW*COL returns 0.
- Widths: wr_ptr is AW+1 bits so the full condition is exact. Line and run counters saturate at 2^CW-1.

Decomposition:
- Resolution macros (`ROW, `COL) and the image file name (`PICTURE) stay in the shared my_video_define.v; no new typedefs needed.
- One natural sub-module: gray_frame_ram, a simple dual-port RAM (1 write, 1 synchronous read, ROW*COL x 8). The FSM, counters and checks stay in gray_capture.

Test Plan:
- gray_gen drives a 50x50 `PICTURE frame -> one frame_done, line_cnt=50, all err_*=0, frame_cnt=1, all 2500 rd_data values match the hex file with 1-cycle latency.
- Line 10 forced to 49 de cycles -> err_len=1, err_lines=0, err_ovf=0. Line 10 forced to 51 de cycles -> err_len=1, err_ovf=1, and mem[2499] holds the last in-range pixel.
- 51 lines of 50 pixels -> line_cnt=51, err_lines=1, err_ovf=1. Next clean frame -> all flags return to 0.
- rst released while vs=1 mid-frame -> no writes and no frame_done until the next vs rise; the following full frame captures correctly.
- rst pulsed for 1 cycle at pixel 1000 of frame 3 -> frame_cnt=0 and statistics cleared immediately; frame 4 captures cleanly with frame_cnt=1.
- Ten back-to-back frames with the minimum 1-cycle vs low gap -> ten frame_done pulses, frame_cnt=10. With frame_cnt preset near wrap (forced to 65535), the next done gives 0.

Source files
------------

// File: rtl/gray_capture_pkg.sv
// ============================================================================
// Module  : gray_capture_pkg
// Purpose : Shared types and defaults for the gray video capture sink.
//           Frame geometry normally comes from the `ROW / `COL macros of the
//           shared video define file; fallbacks keep the block buildable
//           stand-alone.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef ROW
`define ROW 50
`endif
`ifndef COL
`define COL 50
`endif

package gray_capture_pkg;

    localparam int DEF_ROW = `ROW;
    localparam int DEF_COL = `COL;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_t;

    // Number of pixels in one frame
    function automatic int frame_depth(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_frame_ram.sv
// ============================================================================
// Module  : gray_frame_ram
// Purpose : Simple dual-port frame buffer, one write port and one read port
//           with a registered (1-cycle) read. Read-during-write to the same
//           address returns the previous contents. Out-of-range read
//           addresses return 0. Contents are not cleared by reset.
// Ports   : clk, rst         clock / async active-high reset (read reg only)
//           i_wr_en          write strobe
//           i_wr_addr        write address (must be < DEPTH)
//           i_wr_data        write data
//           i_rd_addr        read address
//           o_rd_data        read data, valid the cycle after i_rd_addr
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_frame_ram #(
    parameter int DEPTH = 2500,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // DEPTH is generally not a power of two, so guard the unused tail
    always_comb begin
        rd_data_d = 8'h00;
        if ({1'b0, i_rd_addr} < c_depth) begin
            rd_data_d = mem[i_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/gray_capture.sv
// ============================================================================
// Module  : gray_capture
// Purpose : Video sink. Captures one ROW x COL frame of an hs/vs/de + 8-bit
//           gray stream into a frame buffer in raster order and reports
//           frame geometry statistics.
// Ports   : video_clk, rst   pixel clock / async active-high reset
//           hs, vs, de       video timing (hs is not used for addressing)
//           iGray            pixel data, qualified by de
//           rd_addr/rd_data  synchronous read port, 1-cycle latency
//           frame_done       1-cycle pulse when a frame has been closed
//           frame_cnt        completed frames (wraps)
//           line_cnt         de bursts in the last completed frame
//           err_len          a burst length differed from COL
//           err_lines        line count differed from ROW
//           err_ovf          more than ROW*COL pixels (excess dropped)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gray_capture
    import gray_capture_pkg::*;
#(
    parameter int COL = DEF_COL,
    parameter int ROW = DEF_ROW,
    parameter int AW  = $clog2(ROW * COL),
    parameter int CW  = 12
) (
    input  logic          video_clk,
    input  logic          rst,
    input  logic          hs,
    input  logic          vs,
    input  logic          de,
    input  logic [7:0]    iGray,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_done,
    output logic [15:0]   frame_cnt,
    output logic [CW-1:0] line_cnt,
    output logic          err_len,
    output logic          err_lines,
    output logic          err_ovf
);

    localparam int            DEPTH     = frame_depth(ROW, COL);
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [CW-1:0] c_col     = CW'(COL);
    localparam logic [CW-1:0] c_row     = CW'(ROW);

    cap_state_t    state_q,     state_d;
    logic          vs_dly_q,    vs_dly_d;
    logic          de_dly_q,    de_dly_d;
    logic [AW:0]   wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0] run_len_q,   run_len_d;
    logic [CW-1:0] lines_q,     lines_d;
    logic          wlen_q,      wlen_d;
    logic          wovf_q,      wovf_d;
    logic [CW-1:0] line_cnt_q,  line_cnt_d;
    logic          err_len_q,   err_len_d;
    logic          err_lines_q, err_lines_d;
    logic          err_ovf_q,   err_ovf_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_de_fall;
    logic w_wr_en;
    logic w_unused_hs;

    assign w_vs_rise   = vs & ~vs_dly_q;
    assign w_vs_fall   = ~vs & vs_dly_q;
    assign w_de_fall   = ~de & de_dly_q;
    assign w_unused_hs = hs;

    always_comb begin
        state_d     = state_q;
        vs_dly_d    = vs;
        de_dly_d    = de;
        wr_ptr_d    = wr_ptr_q;
        run_len_d   = run_len_q;
        lines_d     = lines_q;
        wlen_d      = wlen_q;
        wovf_d      = wovf_q;
        line_cnt_d  = line_cnt_q;
        err_len_d   = err_len_q;
        err_lines_d = err_lines_q;
        err_ovf_d   = err_ovf_q;
        frame_cnt_d = frame_cnt_q;
        w_wr_en     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // DONE lasts exactly one cycle; a vs rise in that cycle
                // starts the next frame without passing through IDLE.
                state_d = ST_IDLE;
                if (w_vs_rise) begin
                    state_d   = ST_CAPTURE;
                    wr_ptr_d  = '0;
                    run_len_d = '0;
                    lines_d   = '0;
                    wlen_d    = 1'b0;
                    wovf_d    = 1'b0;
                end
            end

            ST_CAPTURE: begin
                if (w_vs_fall) begin
                    // A burst still open at frame end (de falling now or
                    // still high) is closed here, exactly once.
                    if (de_dly_q) begin
                        if (lines_q != c_cnt_max) begin
                            lines_d = lines_q + 1'b1;
                        end
                        if (run_len_q != c_col) begin
                            wlen_d = 1'b1;
                        end
                    end
                    run_len_d   = '0;
                    // Publish on entry so status is valid alongside frame_done
                    line_cnt_d  = lines_d;
                    err_len_d   = wlen_d;
                    err_lines_d = (lines_d != c_row);
                    err_ovf_d   = wovf_q;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = ST_DONE;
                end else begin
                    if (de) begin
                        if (wr_ptr_q < c_depth) begin
                            w_wr_en  = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end else begin
                            wovf_d = 1'b1;
                        end
                        if (run_len_q != c_cnt_max) begin
                            run_len_d = run_len_q + 1'b1;
                        end
                    end
                    if (w_de_fall) begin
                        if (lines_q != c_cnt_max) begin
                            lines_d = lines_q + 1'b1;
                        end
                        if (run_len_q != c_col) begin
                            wlen_d = 1'b1;
                        end
                        run_len_d = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            // Treat vs as already high so a frame in progress at reset
            // release does not look like a fresh vs rise.
            vs_dly_q    <= 1'b1;
            de_dly_q    <= 1'b0;
            wr_ptr_q    <= '0;
            run_len_q   <= '0;
            lines_q     <= '0;
            wlen_q      <= 1'b0;
            wovf_q      <= 1'b0;
            line_cnt_q  <= '0;
            err_len_q   <= 1'b0;
            err_lines_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            vs_dly_q    <= vs_dly_d;
            de_dly_q    <= de_dly_d;
            wr_ptr_q    <= wr_ptr_d;
            run_len_q   <= run_len_d;
            lines_q     <= lines_d;
            wlen_q      <= wlen_d;
            wovf_q      <= wovf_d;
            line_cnt_q  <= line_cnt_d;
            err_len_q   <= err_len_d;
            err_lines_q <= err_lines_d;
            err_ovf_q   <= err_ovf_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    gray_frame_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (video_clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_ptr_q[AW-1:0]),
        .i_wr_data (iGray),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data)
    );

    assign frame_done = (state_q == ST_DONE);
    assign frame_cnt  = frame_cnt_q;
    assign line_cnt   = line_cnt_q;
    assign err_len    = err_len_q;
    assign err_lines  = err_lines_q;
    assign err_ovf    = err_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_capture.sv
// ============================================================================
// Module  : tb_gray_capture
// Purpose : Self-checking bench for gray_capture. A table of frame shapes
//           with hand-derived status values, a pixel model of the frame
//           buffer for readback, and directed sequences for reset, back-to-
//           back frames and frame counter wrap.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gray_capture;

    localparam int ROW = 12;
    localparam int COL = 16;
    localparam int CW  = 12;
    localparam int N   = ROW * COL;
    localparam int AW  = $clog2(N);

    logic          video_clk = 1'b0;
    logic          rst;
    logic          hs;
    logic          vs;
    logic          de;
    logic [7:0]    iGray;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_done;
    logic [15:0]   frame_cnt;
    logic [CW-1:0] line_cnt;
    logic          err_len;
    logic          err_lines;
    logic          err_ovf;

    gray_capture #(
        .COL (COL),
        .ROW (ROW),
        .AW  (AW),
        .CW  (CW)
    ) dut (
        .video_clk  (video_clk),
        .rst        (rst),
        .hs         (hs),
        .vs         (vs),
        .de         (de),
        .iGray      (iGray),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .line_cnt   (line_cnt),
        .err_len    (err_len),
        .err_lines  (err_lines),
        .err_ovf    (err_ovf)
    );

    always #5 video_clk = ~video_clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          done_seen = 0;
    int          mptr;
    bit          rdw_en = 1'b0;
    logic [15:0] exp_fc;
    logic [7:0]  exp_mem [N];

    // Sampled status in the cycle after vs is first seen low
    logic          s_done;
    logic [CW-1:0] s_lc;
    logic          s_len, s_lines, s_ovf;
    logic [15:0]   s_fc;

    typedef struct {
        int nlines;
        int bad_line;
        int bad_len;
        int tail;      // 1: last burst ends on the same edge as vs
        int e_lc;
        bit e_len;
        bit e_lines;
        bit e_ovf;
    } vec_t;

    vec_t tbl [7];

    always @(negedge video_clk) begin
        if (frame_done) done_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge video_clk);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic logic [7:0] pix(input int seed, input int y, input int x);
        return 8'(seed * 37 + y * 16 + x * 3 + 5);
    endfunction

    task automatic hblank();
        de = 1'b0;
        hs = 1'b1;
        step();
        hs = 1'b0;
        step();
    endtask

    task automatic drive_line(input int seed, input int y, input int len, input bit model);
        logic [7:0] old0;
        old0 = 8'h00;
        for (int x = 0; x < len; x++) begin
            de    = 1'b1;
            iGray = pix(seed, y, x);
            if (model && y == 0 && x == 0) old0 = exp_mem[0];
            if (model) begin
                if (mptr < N) exp_mem[mptr] = iGray;
                mptr++;
            end
            step();
            // rd_addr is parked at 0 while capturing
            if (rdw_en && model && y == 0 && x == 0) check("rd_during_wr_old", rd_data, old0);
            if (rdw_en && model && y == 0 && x == 1) check("rd_after_wr_new", rd_data, pix(seed, 0, 0));
        end
    endtask

    task automatic run_frame(input int nlines, input int bad_line, input int bad_len,
                             input int tail, input int gap, input int seed);
        vs      = 1'b1;
        de      = 1'b0;
        rd_addr = '0;
        step();
        mptr = 0;
        for (int y = 0; y < nlines; y++) begin
            drive_line(seed, y, (y == bad_line) ? bad_len : COL, 1'b1);
            if (!(tail == 1 && y == nlines - 1)) hblank();
        end
        vs = 1'b0;
        de = 1'b0;
        step();
        s_done  = frame_done;
        s_lc    = line_cnt;
        s_len   = err_len;
        s_lines = err_lines;
        s_ovf   = err_ovf;
        s_fc    = frame_cnt;
        exp_fc  = exp_fc + 16'd1;
        for (int g = 1; g < gap; g++) step();
    endtask

    task automatic readback(input string name);
        int         bad;
        int         first;
        logic [7:0] g_first;
        logic [7:0] e_first;
        bad = 0;
        first = -1;
        g_first = 8'h00;
        e_first = 8'h00;
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a);
            step();
            if (rd_data !== exp_mem[a]) begin
                if (first < 0) begin
                    first   = a;
                    g_first = rd_data;
                    e_first = exp_mem[a];
                end
                bad++;
            end
        end
        n_checks++;
        if (bad == 0) n_pass++;
        else $display("FAIL %s: %0d bytes differ, first addr %0d got %0d expected %0d",
                      name, bad, first, g_first, e_first);
        rd_addr = '0;
    endtask

    initial begin
        int base;

        tbl[0] = '{ROW,     -1, 0,       0, ROW,     1'b0, 1'b0, 1'b0};
        tbl[1] = '{ROW,      9, COL - 1, 0, ROW,     1'b1, 1'b0, 1'b0};
        tbl[2] = '{ROW,      9, COL + 1, 0, ROW,     1'b1, 1'b0, 1'b1};
        tbl[3] = '{ROW + 1, -1, 0,       0, ROW + 1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{ROW,     -1, 0,       0, ROW,     1'b0, 1'b0, 1'b0};
        tbl[5] = '{ROW,     -1, 0,       1, ROW,     1'b0, 1'b0, 1'b0};
        tbl[6] = '{ROW - 1, -1, 0,       0, ROW - 1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; iGray = 8'h00; rd_addr = '0;
        exp_fc = 16'd0;
        mptr = 0;
        repeat (3) step();
        check("reset frame_done", frame_done, 0);
        check("reset frame_cnt",  frame_cnt,  0);
        check("reset line_cnt",   line_cnt,   0);
        check("reset err_len",    err_len,    0);
        check("reset err_lines",  err_lines,  0);
        check("reset err_ovf",    err_ovf,    0);
        check("reset rd_data",    rd_data,    0);
        rst = 1'b0;
        repeat (3) step();

        // Frame shapes with hand-derived status
        for (int i = 0; i < 7; i++) begin
            base = done_seen;
            run_frame(tbl[i].nlines, tbl[i].bad_line, tbl[i].bad_len, tbl[i].tail, 4, i + 1);
            check($sformatf("row%0d frame_done", i), s_done,  1);
            check($sformatf("row%0d line_cnt", i),   s_lc,    tbl[i].e_lc);
            check($sformatf("row%0d err_len", i),    s_len,   tbl[i].e_len);
            check($sformatf("row%0d err_lines", i),  s_lines, tbl[i].e_lines);
            check($sformatf("row%0d err_ovf", i),    s_ovf,   tbl[i].e_ovf);
            check($sformatf("row%0d frame_cnt", i),  s_fc,    exp_fc);
            check($sformatf("row%0d done_pulses", i), done_seen - base, 1);
            readback($sformatf("row%0d readback", i));
            rdw_en = 1'b1;
        end

        // Out-of-range reads return zero
        rd_addr = AW'(N);
        step();
        check("rd_oob_first", rd_data, 0);
        rd_addr = '1;
        step();
        check("rd_oob_last", rd_data, 0);
        rd_addr = '0;

        // Reset pulse mid-frame, released while vs is still high
        base = done_seen;
        vs = 1'b1;
        de = 1'b0;
        step();
        mptr = 0;
        for (int y = 0; y < 3; y++) begin
            drive_line(20, y, COL, 1'b1);
            hblank();
        end
        drive_line(20, 3, 5, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst frame_cnt",  frame_cnt,  0);
        check("midrst line_cnt",   line_cnt,   0);
        check("midrst err_lines",  err_lines,  0);
        check("midrst frame_done", frame_done, 0);
        step();
        rst = 1'b0;
        drive_line(21, 3, COL - 5, 1'b0);
        hblank();
        for (int y = 4; y < ROW; y++) begin
            drive_line(21, y, COL, 1'b0);
            hblank();
        end
        vs = 1'b0;
        repeat (4) step();
        exp_fc = 16'd0;
        check("midrst no_done", done_seen - base, 0);
        check("midrst frame_cnt_after", frame_cnt, 0);
        readback("midrst readback");

        run_frame(ROW, -1, 0, 0, 3, 30);
        check("post_rst frame_done", s_done,  1);
        check("post_rst frame_cnt",  s_fc,    exp_fc);
        check("post_rst line_cnt",   s_lc,    ROW);
        check("post_rst err_lines",  s_lines, 0);
        readback("post_rst readback");

        // Ten frames with a single-cycle vs low gap
        base = done_seen;
        for (int k = 0; k < 10; k++) begin
            run_frame(ROW, -1, 0, 0, 1, 40 + k);
            check($sformatf("b2b%0d line_cnt", k), s_lc, ROW);
        end
        repeat (3) step();
        check("b2b done_pulses", done_seen - base, 10);
        check("b2b frame_cnt",   frame_cnt, exp_fc);
        check("b2b err_len",     err_len,   0);
        readback("b2b readback");

        // Frame counter wrap
        force dut.frame_cnt_q = 16'hFFFF;
        step();
        release dut.frame_cnt_q;
        exp_fc = 16'hFFFF;
        run_frame(ROW, -1, 0, 0, 3, 60);
        check("wrap frame_cnt", s_fc, exp_fc);
        check("wrap frame_done", s_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
